// File: rtl/hs32_pkg.sv
// Shared definitions for the HS32 execute pipeline: opcodes, instruction field
// positions and the stage-register layout used by D, E and W.
package hs32_pkg;

    localparam logic [7:0] OP_NOP  = 8'h00;
    localparam logic [7:0] OP_MOVI = 8'h01;
    localparam logic [7:0] OP_MOV  = 8'h02;
    localparam logic [7:0] OP_ADD  = 8'h10;
    localparam logic [7:0] OP_SUB  = 8'h11;
    localparam logic [7:0] OP_AND  = 8'h12;
    localparam logic [7:0] OP_OR   = 8'h13;
    localparam logic [7:0] OP_XOR  = 8'h14;
    localparam logic [7:0] OP_ADDI = 8'h18;

    localparam int OPC_HI = 31;
    localparam int OPC_LO = 24;
    localparam int RD_HI  = 23;
    localparam int RD_LO  = 20;
    localparam int RM_HI  = 19;
    localparam int RM_LO  = 16;
    localparam int RN_HI  = 15;
    localparam int RN_LO  = 12;
    localparam int IMM_HI = 15;
    localparam int IMM_LO = 0;

    typedef struct packed {
        logic        valid;
        logic [7:0]  opcode;
        logic [3:0]  rd;
        logic [3:0]  rm;
        logic [3:0]  rn;
        logic [31:0] imm;
        logic        bank;
        logic [31:0] result;
    } stage_t;

    // True for opcodes that produce a register result; everything else is a NOP.
    function automatic logic op_writes(input logic [7:0] opc);
        logic w;
        case (opc)
            OP_MOVI, OP_MOV, OP_ADD, OP_SUB, OP_AND,
            OP_OR, OP_XOR, OP_ADDI: w = 1'b1;
            default:                w = 1'b0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/hs32_regfile.sv
// 16x32 register file with two async read ports and one write port.
// With HS32_BANKED_REGS_EN defined a second bank is selected by the bank inputs.
module hs32_regfile
    import hs32_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR_REGS = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rp1_bank_i,
    input  logic [3:0]  rp1_addr_i,
    output logic [31:0] rp1_data_o,
    input  logic        rp2_bank_i,
    input  logic [3:0]  rp2_addr_i,
    output logic [31:0] rp2_data_o,
    input  logic        wp1_we1_i,
    input  logic        wp1_we2_i,
    input  logic [3:0]  wp1_addr_i,
    input  logic [31:0] wp1_data_i
);

    logic [31:0] bank0_q [16];
    logic [31:0] bank0_d [16];

    // Bank 0 next-state: single write port.
    always_comb begin
        bank0_d = bank0_q;
        if (wp1_we1_i) begin
            bank0_d[wp1_addr_i] = wp1_data_i;
        end else begin
            bank0_d = bank0_q;
        end
    end

    // Bank 0 storage with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                bank0_q[i] <= RESET_VECTOR_REGS;
            end
        end else begin
            bank0_q <= bank0_d;
        end
    end

`ifdef HS32_BANKED_REGS_EN
    logic [31:0] bank1_q [16];
    logic [31:0] bank1_d [16];

    // Bank 1 next-state.
    always_comb begin
        bank1_d = bank1_q;
        if (wp1_we2_i) begin
            bank1_d[wp1_addr_i] = wp1_data_i;
        end else begin
            bank1_d = bank1_q;
        end
    end

    // Bank 1 storage with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                bank1_q[i] <= RESET_VECTOR_REGS;
            end
        end else begin
            bank1_q <= bank1_d;
        end
    end

    assign rp1_data_o = rp1_bank_i ? bank1_q[rp1_addr_i] : bank0_q[rp1_addr_i];
    assign rp2_data_o = rp2_bank_i ? bank1_q[rp2_addr_i] : bank0_q[rp2_addr_i];
`else
    logic unused_bank_s;
    assign unused_bank_s = ^{rp1_bank_i, rp2_bank_i, wp1_we2_i};

    assign rp1_data_o = bank0_q[rp1_addr_i];
    assign rp2_data_o = bank0_q[rp2_addr_i];
`endif

endmodule

// File: rtl/hs32_pipeline.sv
// HS32 three-stage (D/E/W) integer execute pipeline with valid/ready in and out.
// Optional HS32_BANKED_REGS_EN: banksel_i selects one of two register banks per op.
module hs32_pipeline
    import hs32_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR_REGS = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [31:0] op_i,
    input  logic        banksel_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [31:0] data_o
);

    stage_t      d_q, d_d, e_q, e_d, w_q, w_d;
    logic [31:0] data_q, data_d;
    logic        advance_s, commit_s, w_writes_s, e_writes_s, in_bank_s;
    logic        wp1_we1_s, wp1_we2_s;
    logic [31:0] rf_a_s, rf_b_s, opa_s, opb_s, alu_s;
    logic        unused_w_s;

    // The whole pipeline moves together unless W holds a result the sink refuses.
    assign advance_s  = !(w_q.valid && !ready_i);
    assign ready_o    = advance_s;
    assign w_writes_s = w_q.valid && op_writes(w_q.opcode);
    assign e_writes_s = e_q.valid && op_writes(e_q.opcode);
    assign commit_s   = w_writes_s && ready_i && !reset;
    assign valid_o    = w_writes_s;
    assign data_o     = data_q;
    assign unused_w_s = ^{w_q.rm, w_q.rn, w_q.imm};

`ifdef HS32_BANKED_REGS_EN
    assign in_bank_s = banksel_i;
    assign wp1_we1_s = commit_s && !w_q.bank;
    assign wp1_we2_s = commit_s && w_q.bank;
`else
    logic unused_banksel_s;
    assign unused_banksel_s = banksel_i;
    assign in_bank_s = 1'b0;
    assign wp1_we1_s = commit_s;
    assign wp1_we2_s = 1'b0;
`endif

    hs32_regfile #(
        .RESET_VECTOR_REGS(RESET_VECTOR_REGS)
    ) regfile (
        .clk        (clk),
        .reset      (reset),
        .rp1_bank_i (e_q.bank),
        .rp1_addr_i (e_q.rm),
        .rp1_data_o (rf_a_s),
        .rp2_bank_i (e_q.bank),
        .rp2_addr_i (e_q.rn),
        .rp2_data_o (rf_b_s),
        .wp1_we1_i  (wp1_we1_s),
        .wp1_we2_i  (wp1_we2_s),
        .wp1_addr_i (w_q.rd),
        .wp1_data_i (w_q.result)
    );

    // Operand selection: an uncommitted W result to the same bank/register wins.
    always_comb begin
        opa_s = rf_a_s;
        opb_s = rf_b_s;
        if (w_writes_s && (w_q.bank == e_q.bank) && (w_q.rd == e_q.rm)) begin
            opa_s = w_q.result;
        end else begin
            opa_s = rf_a_s;
        end
        if (w_writes_s && (w_q.bank == e_q.bank) && (w_q.rd == e_q.rn)) begin
            opb_s = w_q.result;
        end else begin
            opb_s = rf_b_s;
        end
    end

    // Execute-stage ALU.
    always_comb begin
        alu_s = 32'h0000_0000;
        case (e_q.opcode)
            OP_MOVI: alu_s = e_q.imm;
            OP_MOV:  alu_s = opa_s;
            OP_ADD:  alu_s = opa_s + opb_s;
            OP_SUB:  alu_s = opa_s - opb_s;
            OP_AND:  alu_s = opa_s & opb_s;
            OP_OR:   alu_s = opa_s | opb_s;
            OP_XOR:  alu_s = opa_s ^ opb_s;
            OP_ADDI: alu_s = opa_s + e_q.imm;
            default: alu_s = 32'h0000_0000;
        endcase
    end

    // Stage advance: decode into D, shift D->E->W, capture the result shown on data_o.
    always_comb begin
        d_d    = d_q;
        e_d    = e_q;
        w_d    = w_q;
        data_d = data_q;
        if (advance_s) begin
            d_d = '0;
            if (valid_i) begin
                d_d.valid  = 1'b1;
                d_d.opcode = op_i[OPC_HI:OPC_LO];
                d_d.rd     = op_i[RD_HI:RD_LO];
                d_d.rm     = op_i[RM_HI:RM_LO];
                d_d.rn     = op_i[RN_HI:RN_LO];
                d_d.imm    = {16'h0000, op_i[IMM_HI:IMM_LO]};
                d_d.bank   = in_bank_s;
            end else begin
                d_d.valid  = 1'b0;
            end
            e_d        = d_q;
            w_d        = e_q;
            w_d.result = alu_s;
            if (e_writes_s) begin
                data_d = alu_s;
            end else begin
                data_d = data_q;
            end
        end else begin
            data_d = data_q;
        end
    end

    // Stage registers; reset discards everything in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            d_q    <= '0;
            e_q    <= '0;
            w_q    <= '0;
            data_q <= 32'h0000_0000;
        end else begin
            d_q    <= d_d;
            e_q    <= e_d;
            w_q    <= w_d;
            data_q <= data_d;
        end
    end

endmodule

// File: tb/tb_hs32_pipeline.sv
// Self-checking bench for hs32_pipeline: architectural model plus directed vectors.
module tb_hs32_pipeline;

    logic        clk = 1'b0;
    logic        reset, valid_i, ready_o, banksel_i, valid_o, ready_i;
    logic [31:0] op_i, data_o;

    int checks   = 0;
    int failures = 0;

`ifdef HS32_BANKED_REGS_EN
    localparam bit BANKED = 1'b1;
`else
    localparam bit BANKED = 1'b0;
`endif

    hs32_pipeline #(.RESET_VECTOR_REGS(32'h0000_0000)) dut (
        .clk       (clk),
        .reset     (reset),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .op_i      (op_i),
        .banksel_i (banksel_i),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .data_o    (data_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        bank;
        logic [3:0]  rd;
        logic [31:0] val;
    } exp_t;

    logic [31:0] arch [2][16];
    exp_t        expq[$];
    logic [31:0] got[$];
    int          got_cyc[$];
    int          acc_cyc[$];
    int          cyc        = 0;
    int          we2_pulses = 0;
    logic        prev_rst   = 1'b0;
    logic        prev_stall = 1'b0;
    logic        prev_valid = 1'b0;
    logic [31:0] prev_data  = 32'h0;
    logic        smp_ready  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [31:0] enc(input logic [7:0] opc, input logic [3:0] rd,
                                        input logic [3:0] rm, input logic [15:0] imm);
        return {opc, rd, rm, imm};
    endfunction

    function automatic void model_reset();
        for (int b = 0; b < 2; b++)
            for (int r = 0; r < 16; r++) arch[b][r] = 32'h0;
        expq.delete();
    endfunction

    // Architectural execution at acceptance: in-order results are final values.
    function automatic void model_accept(input logic [31:0] op, input logic b_in);
        logic        b, wr;
        logic [31:0] a, n, imm, r;
        exp_t        e;
        b   = BANKED ? b_in : 1'b0;
        a   = arch[b][op[19:16]];
        n   = arch[b][op[15:12]];
        imm = {16'h0000, op[15:0]};
        wr  = 1'b1;
        r   = 32'h0;
        case (op[31:24])
            8'h01:   r = imm;
            8'h02:   r = a;
            8'h10:   r = a + n;
            8'h11:   r = a - n;
            8'h12:   r = a & n;
            8'h13:   r = a | n;
            8'h14:   r = a ^ n;
            8'h18:   r = a + imm;
            default: wr = 1'b0;
        endcase
        if (wr) begin
            arch[b][op[23:20]] = r;
            e.bank = b;
            e.rd   = op[23:20];
            e.val  = r;
            expq.push_back(e);
        end
    endfunction

    // One clock: compare just before the rising edge, then advance to the next falling edge.
    task automatic cycle(output logic acc);
        exp_t e;
        #4;
        smp_ready = ready_o;
        if (prev_rst) begin
            check("reset_valid_o", {31'b0, valid_o}, 32'h0);
            check("reset_data_o", data_o, 32'h0);
        end
        if (prev_stall) begin
            check("stall_valid_o", {31'b0, valid_o}, {31'b0, prev_valid});
            check("stall_data_o", data_o, prev_data);
        end
        if (!reset) begin
            if (dut.regfile.wp1_we2_i) we2_pulses++;
            if (valid_o && ready_i) begin
                check("commit_pending", {31'b0, (expq.size() > 0)}, 32'h1);
                if (expq.size() > 0) begin
                    e = expq.pop_front();
                    check("commit_data", data_o, e.val);
                    check("wp_we1", {31'b0, dut.regfile.wp1_we1_i}, {31'b0, !e.bank});
                    check("wp_we2", {31'b0, dut.regfile.wp1_we2_i}, {31'b0, e.bank});
                    check("wp_addr", {28'b0, dut.regfile.wp1_addr_i}, {28'b0, e.rd});
                    check("wp_data", dut.regfile.wp1_data_i, e.val);
                end
                got.push_back(data_o);
                got_cyc.push_back(cyc);
            end else begin
                check("no_write", {30'b0, dut.regfile.wp1_we1_i, dut.regfile.wp1_we2_i}, 32'h0);
            end
        end
        acc = valid_i && ready_o && !reset;
        if (reset) begin
            model_reset();
        end else if (acc) begin
            model_accept(op_i, banksel_i);
            acc_cyc.push_back(cyc);
        end
        prev_rst   = reset;
        prev_stall = valid_o && !ready_i && !reset;
        prev_valid = valid_o;
        prev_data  = data_o;
        cyc++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic [31:0] op, input logic b);
        logic acc;
        int   tries;
        valid_i   = 1'b1;
        op_i      = op;
        banksel_i = b;
        acc       = 1'b0;
        tries     = 0;
        while (!acc && tries < 50) begin
            cycle(acc);
            tries++;
        end
        check("accept_timeout", {31'b0, acc}, 32'h1);
        valid_i = 1'b0;
    endtask

    task automatic idle(input int n);
        logic acc;
        valid_i = 1'b0;
        for (int i = 0; i < n; i++) cycle(acc);
    endtask

    task automatic new_test();
        got.delete();
        got_cyc.delete();
        acc_cyc.delete();
        we2_pulses = 0;
    endtask

    initial begin
        logic acc;
        reset = 1'b1; valid_i = 1'b0; ready_i = 1'b1; op_i = 32'h0; banksel_i = 1'b0;
        model_reset();
        @(negedge clk);
        cycle(acc);
        cycle(acc);
        reset = 1'b0;
        idle(1);

        // Two MOVIs: first commit three cycles after acceptance, then one per cycle.
        new_test();
        send(enc(8'h01, 4'd1, 4'd0, 16'h1234), 1'b0);
        send(enc(8'h01, 4'd2, 4'd0, 16'h0001), 1'b0);
        idle(5);
        check("t1_count", got.size(), 32'd2);
        if (got.size() == 2) begin
            check("t1_r1", got[0], 32'h0000_1234);
            check("t1_r2", got[1], 32'h0000_0001);
            check("t1_latency", got_cyc[0] - acc_cyc[0], 32'd3);
            check("t1_spacing", got_cyc[1] - got_cyc[0], 32'd1);
        end

        // Back-to-back dependency resolved by forwarding, no bubble.
        new_test();
        send(enc(8'h01, 4'd1, 4'd0, 16'h0005), 1'b0);
        send(enc(8'h01, 4'd2, 4'd0, 16'h0007), 1'b0);
        send(enc(8'h10, 4'd3, 4'd1, 16'h2000), 1'b0);
        idle(5);
        check("t2_count", got.size(), 32'd3);
        if (got.size() == 3) begin
            check("t2_add", got[2], 32'h0000_000C);
            check("t2_no_bubble", got_cyc[2] - got_cyc[0], 32'd2);
        end

        // Immediate carry past 16 bits, self-subtract, and 0-1 wraparound.
        new_test();
        send(enc(8'h01, 4'd1, 4'd0, 16'h0000), 1'b0);
        send(enc(8'h18, 4'd1, 4'd1, 16'hFFFF), 1'b0);
        send(enc(8'h18, 4'd1, 4'd1, 16'hFFFF), 1'b0);
        send(enc(8'h11, 4'd2, 4'd1, 16'h1000), 1'b0);
        send(enc(8'h01, 4'd5, 4'd0, 16'h0000), 1'b0);
        send(enc(8'h01, 4'd6, 4'd0, 16'h0001), 1'b0);
        send(enc(8'h11, 4'd4, 4'd5, 16'h6000), 1'b0);
        idle(5);
        check("t3_count", got.size(), 32'd7);
        if (got.size() == 7) begin
            check("t3_r1", got[2], 32'h0001_FFFE);
            check("t3_r2", got[3], 32'h0000_0000);
            check("t3_r4", got[6], 32'hFFFF_FFFF);
        end

        // Sink stall with three ops in flight and a fourth waiting at the input.
        new_test();
        send(enc(8'h01, 4'd7, 4'd0, 16'h0011), 1'b0);
        send(enc(8'h18, 4'd8, 4'd7, 16'h0001), 1'b0);
        send(enc(8'h10, 4'd9, 4'd8, 16'h7000), 1'b0);
        ready_i = 1'b0;
        valid_i = 1'b1;
        op_i    = enc(8'h02, 4'd10, 4'd9, 16'h0000);
        for (int i = 0; i < 4; i++) begin
            cycle(acc);
            check("stall_ready_o", {31'b0, smp_ready}, 32'h0);
            check("stall_no_accept", {31'b0, acc}, 32'h0);
        end
        check("stall_no_commit", got.size(), 32'd0);
        ready_i = 1'b1;
        send(enc(8'h02, 4'd10, 4'd9, 16'h0000), 1'b0);
        idle(5);
        check("t4_count", got.size(), 32'd4);
        if (got.size() == 4) begin
            check("t4_a", got[0], 32'h0000_0011);
            check("t4_b", got[1], 32'h0000_0012);
            check("t4_c", got[2], 32'h0000_0023);
            check("t4_d", got[3], 32'h0000_0023);
            check("t4_order", got_cyc[2] - got_cyc[0], 32'd2);
        end

        // Bank selection: MOV in bank 0 must not see the bank-1 write.
        new_test();
        send(enc(8'h01, 4'd1, 4'd0, 16'hAAAA), 1'b0);
        send(enc(8'h01, 4'd1, 4'd0, 16'h5555), 1'b1);
        send(enc(8'h02, 4'd2, 4'd1, 16'h0000), 1'b0);
        idle(5);
        check("t5_count", got.size(), 32'd3);
        if (got.size() == 3) begin
            check("t5_mov", got[2], BANKED ? 32'h0000_AAAA : 32'h0000_5555);
        end
        check("t5_we2_pulses", we2_pulses, BANKED ? 32'd1 : 32'd0);

        // Reset with two ops in flight, then an invalid opcode and a NOP.
        new_test();
        send(enc(8'h01, 4'd10, 4'd0, 16'h0077), 1'b0);
        send(enc(8'h01, 4'd11, 4'd0, 16'h0088), 1'b0);
        reset = 1'b1;
        cycle(acc);
        cycle(acc);
        reset = 1'b0;
        idle(4);
        check("t6_discarded", got.size(), 32'd0);
        send(enc(8'h7F, 4'd3, 4'd0, 16'h1234), 1'b0);
        send(enc(8'h00, 4'd3, 4'd0, 16'h5678), 1'b0);
        send(enc(8'h02, 4'd12, 4'd10, 16'h0000), 1'b0);
        send(enc(8'h02, 4'd13, 4'd3, 16'h0000), 1'b0);
        idle(6);
        check("t6_count", got.size(), 32'd2);
        if (got.size() == 2) begin
            check("t6_r10_reset", got[0], 32'h0000_0000);
            check("t6_r3_untouched", got[1], 32'h0000_0000);
        end

        check("final_queue_empty", expq.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hs32_pipeline.md
Name: hs32_pipeline

Overview:
- Three-stage in-order integer execute pipeline for the HS32 core: Decode/Read (D), Execute (E), Writeback (W).
- Takes 32-bit instruction words over a valid/ready stream and executes register/immediate ALU ops against an internal 16x32 register file (two banks).
- Emits each committed result on a valid/ready output stream.
- Sits between instruction fetch and downstream consumers (trace/commit sink).

Parameters:
- RESET_VECTOR_REGS, 0, reset value loaded into every register-file entry.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- valid_i  in  1  op_i holds an instruction.
- ready_o  out  1  pipeline accepts op_i this cycle.
- op_i  in  32  instruction word.
- banksel_i  in  1  register bank for this instruction, sampled with op_i.
- valid_o  out  1  data_o holds a committed result.
- ready_i  in  1  sink accepts data_o.
- data_o  out  32  result of the committing instruction.

Behaviour:
- Reset: reset (synchronous, active-high; clock clk) clears D/E/W valid bits. All register-file entries are set to RESET_VECTOR_REGS. valid_o=0 and data_o=0 during and after reset until the first commit.
- Encoding: opcode=op[31:24], rd=op[23:20], rm=op[19:16], rn=op[15:12], imm16=op[15:0], zero-extended.
- Opcodes:
  - 0x00 NOP.
  - 0x01 MOVI rd=imm16.
  - 0x02 MOV rd=rm.
  - 0x10 ADD rd=rm+rn.
  - 0x11 SUB rd=rm-rn.
  - 0x12 AND.
  - 0x13 OR.
  - 0x14 XOR.
  - 0x18 ADDI rd=rm+imm16.
  - Any other opcode behaves as NOP.
- Arithmetic: 32-bit, modulo 2^32, no flags.
- Handshake: instruction accepted on a rising edge when valid_i && ready_o.
  - ready_o = !(W.valid && !ready_i), so the whole pipeline stalls together.
  - During a stall, all stage registers hold and op_i is not consumed.
- Latency:
  - Instruction accepted at edge t0 is in D after t0, in E after t1, in W after t2.
  - valid_o=1 during the cycle after t2 when W holds a non-NOP; data_o is its result.
  - NOPs and invalid opcodes travel through the pipeline but never raise valid_o and never write.
- Writeback: occurs in the handshake cycle W.valid && ready_i. The register updates at that edge, exactly once per instruction.
  - Write port: wp1_addr_i=rd, wp1_data_i=result, wp1_we1_i for bank 0, wp1_we2_i for bank 1.
- Operand read: in E, from the instruction's bank, with forwarding priority W result > register file.
  - Only a W result to the same bank and register is forwarded.
  - Back-to-back dependent instructions never stall and always see the newest value.
- Reset mid-operation discards every in-flight instruction with no register write.
- Throughput: one instruction per cycle when ready_i=1.

Optional Feature:
- HS32_BANKED_REGS_EN defined: two 16x32 banks; banksel_i travels with each instruction and selects the read/write bank.
- Undefined: single bank; banksel_i ignored; wp1_we2_i tied 0; all writes use wp1_we1_i.

Decomposition:
- Package hs32_pkg: opcode localparams, field bit positions, a stage-register struct typedef (valid, opcode, rd, rm, rn, imm, bank, result).
- Sub-module hs32_regfile:
  - instance name regfile.
  - two async read ports.
  - write port signals wp1_we1_i, wp1_we2_i, wp1_addr_i[3:0], wp1_data_i[31:0].
  - synchronous reset to RESET_VECTOR_REGS.

Test Plan:
- After reset, stream MOVI r1,0x1234 then MOVI r2,0x0001 with ready_i=1: writes r1=00001234, r2=00000001 on consecutive cycles, first write 3 cycles after acceptance.
- MOVI r1,5; MOVI r2,7; ADD r3,r1,r2 back-to-back: r3=0000000C with no bubble (forwarding).
- MOVI r1,0; ADDI r1,r1,0xFFFF twice; SUB r2,r1,r1 then a SUB wrap case r4=0-1: r1=0001FFFE, r2=00000000, r4=FFFFFFFF.
- Hold ready_i=0 for 4 cycles while 3 ops are in flight: ready_o=0, no writes, data_o stable. On release, the three writes occur in order, each exactly once.
- With HS32_BANKED_REGS_EN: MOVI r1,0xAAAA bank0, MOVI r1,0x5555 bank1, MOV r2,r1 bank0: r2(bank0)=0000AAAA; wp1_we2_i pulses only for the bank-1 write.
- Assert reset with 2 instructions in flight: no further register writes, valid_o=0; opcode 0x7F and NOP produce no writes or outputs.
